bp_network_serializer: RTL and testbench



---
 rtl/bp_network_serializer.sv | 123 ++++++++++++
 tb/tb_bp_network_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_network_serializer.sv
// Splits one wide message into num_packets_p flits {dest_id, src_id, payload}, lowest slice first.
// Optional stall counter output enabled by defining BP_NETWORK_SERIALIZER_STALL_CNT_EN.
module bp_network_serializer #(
    parameter int num_dest            = 4,
    parameter int num_src             = 4,
    parameter int source_data_width_p = 64,
    parameter int packet_data_width_p = 16,
    localparam int dest_id_width_p    = (num_dest > 1) ? $clog2(num_dest) : 1,
    localparam int src_id_width_p     = (num_src > 1) ? $clog2(num_src) : 1,
    localparam int num_packets_p      = (source_data_width_p + packet_data_width_p - 1) / packet_data_width_p,
    localparam int total_o_data_width = packet_data_width_p + dest_id_width_p + src_id_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [source_data_width_p-1:0] data_i,
    input  logic [dest_id_width_p-1:0]     dest_id_i,
    input  logic [src_id_width_p-1:0]      src_id_i,
    output logic                           v_o,
    output logic [total_o_data_width-1:0]  data_o,
    input  logic                           ready_i
`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cnt_o
`endif
);

    localparam int cnt_width_lp = (num_packets_p > 1) ? $clog2(num_packets_p) : 1;
    localparam int buf_width_lp = num_packets_p * packet_data_width_p;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                                        state_r, state_n;
    logic [cnt_width_lp-1:0]                       cnt_r, cnt_n;
    logic [num_packets_p-1:0][packet_data_width_p-1:0] buf_r;
    logic [dest_id_width_p-1:0]                    dest_r;
    logic [src_id_width_p-1:0]                     src_r;
    logic [packet_data_width_p-1:0]                payload;
    logic                                          load, last_flit;

    assign last_flit = (cnt_r == cnt_width_lp'(num_packets_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Payload and IDs need no reset; they are only observed while in SEND.
    always_ff @(posedge clk_i) begin
        if (load) begin
            buf_r  <= buf_width_lp'(data_i);
            dest_r <= dest_id_i;
            src_r  <= src_id_i;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        load    = 1'b0;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                v_o     = 1'b1;
                // Accept the next message on the last flit's transfer so there is no bubble.
                ready_o = last_flit & ready_i;
                if (ready_i) begin
                    if (!last_flit) begin
                        cnt_n = cnt_r + 1'b1;
                    end else begin
                        cnt_n = '0;
                        if (v_i) begin
                            load    = 1'b1;
                            state_n = SEND;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    generate
        if (num_packets_p == 1) begin : g_single
            assign payload = buf_r[0];
        end else begin : g_multi
            assign payload = buf_r[cnt_r];
        end
    endgenerate

    assign data_o = {dest_r, src_r, payload};

`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            stall_cnt_r <= '0;
        else if (v_o && !ready_i && !(&stall_cnt_r))
            stall_cnt_r <= stall_cnt_r + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bp_network_serializer.sv
// Bench for bp_network_serializer: vector table, corner-case sequences, and a
// randomized run checked against a flit-queue reference model.
module tb_bp_network_serializer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i, ready_i;
    logic [63:0] data_i;
    logic [1:0]  dest_id_i, src_id_i;
    logic        v_o, ready_o;
    logic [19:0] data_o;

    logic        v40, r40;
    logic [39:0] d40;
    logic [1:0]  dest40, src40;
    logic        v40_o, ready40_o;
    logic [19:0] data40_o;

`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
    logic [31:0] stall_cnt_o, stall40_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_network_serializer #(.num_dest(4), .num_src(4), .source_data_width_p(64), .packet_data_width_p(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .data_i(data_i),
        .dest_id_i(dest_id_i), .src_id_i(src_id_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i)
`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    bp_network_serializer #(.num_dest(4), .num_src(4), .source_data_width_p(40), .packet_data_width_p(16)) dut40 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v40), .ready_o(ready40_o), .data_i(d40),
        .dest_id_i(dest40), .src_id_i(src40), .v_o(v40_o), .data_o(data40_o), .ready_i(r40)
`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
        , .stall_cnt_o(stall40_o)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [1:0]  dst, src;
        bit          r;
        bit          ev, er;
        logic [19:0] ed;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit v, input logic [63:0] d, input logic [1:0] dst, input logic [1:0] src,
                       input bit r, input bit ev, input bit er, input logic [19:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.dst = dst; t.src = src; t.r = r; t.ev = ev; t.er = er; t.ed = ed;
        tv.push_back(t);
    endtask

    // Reference model: the flits still owed downstream, in order.
    logic [19:0] q[$];
    bit          pend = 0;
    logic [63:0] pd;
    logic [1:0]  pdst, psrc;

    task automatic rand_cycle(input bit allow_new, input bit force_rdy);
        bit ev, er;
        @(posedge clk); #1;
        if (!pend && allow_new && $urandom_range(0, 2) != 0) begin
            pend = 1;
            pd   = {$urandom, $urandom};
            pdst = 2'($urandom_range(0, 3));
            psrc = 2'($urandom_range(0, 3));
        end
        v_i       = pend;
        data_i    = pend ? pd : {$urandom, $urandom};
        dest_id_i = pend ? pdst : 2'($urandom_range(0, 3));
        src_id_i  = pend ? psrc : 2'($urandom_range(0, 3));
        ready_i   = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        ev = (q.size() != 0);
        er = (q.size() == 0) || (q.size() == 1 && ready_i);
        chk("rnd v_o", v_o, ev);
        chk("rnd ready_o", ready_o, er);
        if (v_o && ready_i && q.size() != 0) begin
            chk("rnd flit", data_o, q[0]);
            void'(q.pop_front());
        end
        if (v_i && ready_o) begin
            for (int k = 0; k < 4; k++) q.push_back({pdst, psrc, pd[k*16 +: 16]});
            pend = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] D, A, B;
        D = 64'h4444_3333_2222_1111;
        A = 64'hAAAA_BBBB_CCCC_DDDD;
        B = 64'h1234_5678_9ABC_DEF0;

        reset_i = 1; v_i = 0; ready_i = 1; data_i = '0; dest_id_i = '0; src_id_i = '0;
        v40 = 0; r40 = 1; d40 = '0; dest40 = '0; src40 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset v_o", v_o, 0);
        reset_i = 0;
        #1;
        chk("post-reset ready_o", ready_o, 1);
        chk("post-reset v_o", v_o, 0);

        // Basic split
        add(1, D, 2, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_1111);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_2222);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_3333);
        add(0, 0, 0, 0, 1, 1, 1, 20'h9_4444);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        // Backpressure on flit 1
        add(1, D, 2, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_1111);
        add(0, 0, 0, 0, 0, 1, 0, 20'h9_2222);
        add(0, 0, 0, 0, 0, 1, 0, 20'h9_2222);
        add(0, 0, 0, 0, 0, 1, 0, 20'h9_2222);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_2222);
        add(0, 0, 0, 0, 1, 1, 0, 20'h9_3333);
        add(0, 0, 0, 0, 1, 1, 1, 20'h9_4444);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        // Back-to-back, no bubble
        add(1, A, 3, 0, 1, 0, 1, 0);
        add(1, B, 0, 3, 1, 1, 0, 20'hC_DDDD);
        add(1, B, 0, 3, 1, 1, 0, 20'hC_CCCC);
        add(1, B, 0, 3, 1, 1, 0, 20'hC_BBBB);
        add(1, B, 0, 3, 1, 1, 1, 20'hC_AAAA);
        add(0, 0, 0, 0, 1, 1, 0, 20'h3_DEF0);
        add(0, 0, 0, 0, 1, 1, 0, 20'h3_9ABC);
        add(0, 0, 0, 0, 1, 1, 0, 20'h3_5678);
        add(0, 0, 0, 0, 1, 1, 1, 20'h3_1234);
        add(0, 0, 0, 0, 1, 0, 1, 0);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            v_i = tv[i].v; data_i = tv[i].d; dest_id_i = tv[i].dst; src_id_i = tv[i].src; ready_i = tv[i].r;
            #1;
            chk($sformatf("vec%0d v_o", i), v_o, tv[i].ev);
            chk($sformatf("vec%0d ready_o", i), ready_o, tv[i].er);
            if (tv[i].ev) chk($sformatf("vec%0d data_o", i), data_o, tv[i].ed);
        end

        // Reset mid-message
        @(posedge clk); #1; v_i = 1; data_i = D; dest_id_i = 2; src_id_i = 1; ready_i = 1; #1;
        chk("rm accept", ready_o, 1);
        @(posedge clk); #1; v_i = 0; #1;
        chk("rm flit0", data_o, 20'h9_1111);
        @(posedge clk); #1; ready_i = 0; #1;
        chk("rm flit1", data_o, 20'h9_2222);
        #2; reset_i = 1; #1;
        chk("rm async v_o", v_o, 0);
        @(posedge clk); #1; reset_i = 0; #1;
        chk("rm release ready_o", ready_o, 1);
        chk("rm release v_o", v_o, 0);
        @(posedge clk); #1; v_i = 1; data_i = 64'h0123_4567_89AB_CDEF; dest_id_i = 1; src_id_i = 2; ready_i = 1; #1;
        @(posedge clk); #1; v_i = 0; #1;
        chk("rm restart slice0", data_o, 20'h6_CDEF);
        repeat (4) @(posedge clk);
        #2;
        chk("rm drained v_o", v_o, 0);

        // Padding on the 40-bit variant
        @(posedge clk); #1; v40 = 1; d40 = 40'hAB_CDEF_0123; dest40 = 2; src40 = 1; #1;
        chk("pad accept", ready40_o, 1);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] exp_pl;
            exp_pl = (k == 0) ? 16'h0123 : (k == 1) ? 16'hCDEF : 16'h00AB;
            @(posedge clk); #1; v40 = 0; #1;
            chk($sformatf("pad flit%0d", k), data40_o, {4'h9, exp_pl});
        end
        @(posedge clk); #2;
        chk("pad done v_o", v40_o, 0);
`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
        chk("pad stall cnt", stall40_o, 0);
`endif

        // Randomized run against the flit queue model
        for (int i = 0; i < 2000; i++) rand_cycle(1, 0);
        for (int i = 0; i < 40 && (pend || q.size() != 0); i++) rand_cycle(1, 1);
        v_i = 0;
        chk("rnd drained", q.size(), 0);

`ifdef BP_NETWORK_SERIALIZER_STALL_CNT_EN
        @(posedge clk); #1; v_i = 0; ready_i = 1; reset_i = 1; #1;
        chk("stall reset", stall_cnt_o, 0);
        reset_i = 0;
        @(posedge clk); #1; v_i = 1; data_i = D; dest_id_i = 2; src_id_i = 1; ready_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; v_i = 0; ready_i = 0;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1; ready_i = 1;
        end
        @(posedge clk); #1; ready_i = 0; #1;
        chk("stall v_o idle", v_o, 0);
        chk("stall count", stall_cnt_o, 5);
        repeat (3) @(posedge clk);
        #2;
        chk("stall hold idle", stall_cnt_o, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
